// File: rtl/fdma_wr_arbiter_n_if.sv
// fdma_wr_arbiter_n_if: channel-side and FDMA-side write signals of the N-channel write arbiter.
interface fdma_wr_arbiter_n_if #(
    parameter int CH_NUM         = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23
);
    logic [CH_NUM*AXI_ADDR_WIDTH-1:0] s_waddr;
    logic [CH_NUM-1:0]                s_wareq;
    logic [CH_NUM*16-1:0]             s_wsize;
    logic [CH_NUM-1:0]                s_wbusy;
    logic [CH_NUM*AXI_DATA_WIDTH-1:0] s_wdata;
    logic [CH_NUM-1:0]                s_wvalid;
    logic [AXI_ADDR_WIDTH-1:0]        fdma_waddr;
    logic                             fdma_wareq;
    logic [15:0]                      fdma_wsize;
    logic                             fdma_wbusy;
    logic [AXI_DATA_WIDTH-1:0]        fdma_wdata;
    logic                             fdma_wvalid;
    modport master (
        output s_waddr, s_wareq, s_wsize, s_wdata, fdma_wbusy, fdma_wvalid,
        input  s_wbusy, s_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata
    );
    modport slave (
        input  s_waddr, s_wareq, s_wsize, s_wdata, fdma_wbusy, fdma_wvalid,
        output s_wbusy, s_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata
    );
endinterface

// File: rtl/fdma_wr_arbiter_n.sv
// fdma_wr_arbiter_n: arbitrates CH_NUM uidbuf write channels onto one FDMA write master,
// fixed-priority or round-robin, with request withdrawal and per-channel burst counters.
module fdma_wr_arbiter_n #(
    parameter int CH_NUM         = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23,
    parameter int ARB_MODE       = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          ui_clk,
    input  logic                          ui_rstn,
    fdma_wr_arbiter_n_if.slave            bus,
    output logic [CH_NUM-1:0]             grant_o,
    output logic [CH_NUM*CNT_WIDTH-1:0]   burst_cnt_o
);
    localparam int IW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t                             state_q, state_d;
    logic [CH_NUM-1:0]                  grant_q, grant_d;
    logic [IW-1:0]                      own_q, own_d, rr_q, rr_d, win;
    logic [AXI_ADDR_WIDTH-1:0]          waddr_q, waddr_d;
    logic [15:0]                        wsize_q, wsize_d;
    logic                               wareq_q, wareq_d;
    logic [CH_NUM-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IW:0]                        cand;
    logic                               found;

    // Search order starts just after the last served channel; wrap is at CH_NUM, not 2^IW.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            cand = ARB_MODE != 0 ? {1'b0, rr_q} + (IW+1)'(k + 1) : (IW+1)'(k);
            cand = cand >= (IW+1)'(CH_NUM) ? cand - (IW+1)'(CH_NUM) : cand;
            if (!found && bus.s_wareq[cand[IW-1:0]]) begin
                win   = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        rr_d    = rr_q;
        waddr_d = waddr_q;
        wsize_d = wsize_q;
        wareq_d = wareq_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d      = '0;
                grant_d[win] = 1'b1;
                own_d        = win;
                waddr_d      = bus.s_waddr[win*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                wsize_d      = bus.s_wsize[win*16 +: 16];
                wareq_d      = 1'b1;
                state_d      = REQ;
            end
            // An FDMA accept in the same cycle as a withdrawal still commits the burst.
            REQ: if (bus.fdma_wbusy) begin
                wareq_d = 1'b0;
                state_d = BUSY;
            end else if (!bus.s_wareq[own_q]) begin
                wareq_d = 1'b0;
                grant_d = '0;
                state_d = IDLE;
            end
            BUSY: if (!bus.fdma_wbusy) begin
                cnt_d[own_q] = cnt_q[own_q] + 1'b1;
                rr_d         = own_q;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            rr_q    <= IW'(CH_NUM - 1);
            waddr_q <= '0;
            wsize_q <= '0;
            wareq_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            rr_q    <= rr_d;
            waddr_q <= waddr_d;
            wsize_q <= wsize_d;
            wareq_q <= wareq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o         = grant_q;
    assign burst_cnt_o     = cnt_q;
    assign bus.s_wbusy     = state_q != IDLE ? grant_q : '0;
    assign bus.fdma_waddr  = waddr_q;
    assign bus.fdma_wsize  = wsize_q;
    assign bus.fdma_wareq  = wareq_q;
    assign bus.fdma_wdata  = |grant_q ? bus.s_wdata[own_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : '0;
    assign bus.s_wvalid    = grant_q & {CH_NUM{bus.fdma_wvalid}};
endmodule

// File: tb/tb_fdma_wr_arbiter_n.sv
// tb_fdma_wr_arbiter_n: directed checks of a round-robin and a fixed-priority arbiter driven in lockstep.
module tb_fdma_wr_arbiter_n;
    logic ui_clk = 1'b0;
    logic ui_rstn = 1'b0;
    always #5 ui_clk = ~ui_clk;

    fdma_wr_arbiter_n_if #(.CH_NUM(4), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(23)) ifa ();
    fdma_wr_arbiter_n_if #(.CH_NUM(4), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(23)) ifb ();

    logic [3:0]  grant_a, grant_b;
    logic [63:0] cnt_a, cnt_b;

    fdma_wr_arbiter_n #(.CH_NUM(4), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(23), .ARB_MODE(1), .CNT_WIDTH(16)) dut_rr (
        .ui_clk(ui_clk), .ui_rstn(ui_rstn), .bus(ifa.slave), .grant_o(grant_a), .burst_cnt_o(cnt_a)
    );
    fdma_wr_arbiter_n #(.CH_NUM(4), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(23), .ARB_MODE(0), .CNT_WIDTH(16)) dut_fp (
        .ui_clk(ui_clk), .ui_rstn(ui_rstn), .bus(ifb.slave), .grant_o(grant_b), .burst_cnt_o(cnt_b)
    );

    assign ifb.s_waddr     = ifa.s_waddr;
    assign ifb.s_wareq     = ifa.s_wareq;
    assign ifb.s_wsize     = ifa.s_wsize;
    assign ifb.s_wdata     = ifa.s_wdata;
    assign ifb.fdma_wbusy  = ifa.fdma_wbusy;
    assign ifb.fdma_wvalid = ifa.fdma_wvalid;

    int total = 0;
    int bad = 0;
    logic [22:0] addr[4];
    logic [15:0] size[4];
    logic [31:0] data[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [22:0] a, input logic [15:0] s, input logic [31:0] d);
        addr[i] = a;
        size[i] = s;
        data[i] = d;
        ifa.s_waddr[i*23 +: 23] = a;
        ifa.s_wsize[i*16 +: 16] = s;
        ifa.s_wdata[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        @(negedge ui_clk);
        ui_rstn = 1'b0;
        ifa.s_wareq = '0;
        ifa.fdma_wbusy = 1'b0;
        ifa.fdma_wvalid = 1'b0;
        @(negedge ui_clk);
        ui_rstn = 1'b1;
    endtask

    // FDMA model: accept 3 cycles after wareq, stream size[exp] beats, then release.
    task automatic burst(input int exp, input int exp_b, input bit drop);
        int t = 0;
        int vc = 0;
        int err = 0;
        logic [3:0] oh;
        oh = 4'(1 << exp);
        while (!ifa.fdma_wareq && t < 20) begin
            @(negedge ui_clk);
            t++;
        end
        chk("wareq_up", 64'(ifa.fdma_wareq), 64'd1);
        chk("grant", 64'(grant_a), 64'(oh));
        if (exp_b >= 0) chk("grant_fp", 64'(grant_b), 64'(1 << exp_b));
        chk("waddr", 64'(ifa.fdma_waddr), 64'(addr[exp]));
        chk("wsize", 64'(ifa.fdma_wsize), 64'(size[exp]));
        repeat (2) @(negedge ui_clk);
        chk("wareq_hold", 64'(ifa.fdma_wareq), 64'd1);
        ifa.fdma_wbusy = 1'b1;
        if (drop) ifa.s_wareq[exp] = 1'b0;
        @(negedge ui_clk);
        chk("wareq_drop", 64'(ifa.fdma_wareq), 64'd0);
        chk("s_wbusy", 64'(ifa.s_wbusy), 64'(oh));
        for (int b = 0; b < int'(size[exp]); b++) begin
            ifa.fdma_wvalid = 1'b1;
            #1;
            if (ifa.s_wvalid[exp]) vc++;
            if (ifa.s_wvalid !== oh || ifa.fdma_wdata !== data[exp]) err++;
            @(negedge ui_clk);
        end
        ifa.fdma_wvalid = 1'b0;
        ifa.fdma_wbusy = 1'b0;
        chk("beats", 64'(vc), 64'(size[exp]));
        chk("beat_err", 64'(err), 64'd0);
        @(negedge ui_clk);
        chk("grant_idle", 64'(grant_a), 64'd0);
    endtask

    initial begin
        ifa.s_waddr = '0;
        ifa.s_wsize = '0;
        ifa.s_wdata = '0;
        ifa.s_wareq = '0;
        ifa.fdma_wbusy = 1'b0;
        ifa.fdma_wvalid = 1'b0;
        set_ch(0, 23'h100, 16'd4, 32'h1111_0000);
        set_ch(1, 23'h200, 16'd5, 32'h2222_0000);
        set_ch(2, 23'h400, 16'd256, 32'h3333_0000);
        set_ch(3, 23'h800, 16'd3, 32'h4444_0000);
        #2;
        chk("rst_grant", 64'(grant_a), 64'd0);
        chk("rst_wareq", 64'(ifa.fdma_wareq), 64'd0);
        chk("rst_s_wbusy", 64'(ifa.s_wbusy), 64'd0);
        chk("rst_cnt", cnt_a, 64'd0);
        chk("rst_wdata", 64'(ifa.fdma_wdata), 64'd0);
        @(negedge ui_clk);
        ui_rstn = 1'b1;

        // single request from ch2
        @(negedge ui_clk);
        ifa.s_wareq = 4'b0100;
        @(negedge ui_clk);
        chk("latency", 64'(ifa.fdma_wareq), 64'd1);
        burst(2, 2, 1'b1);
        chk("single_cnt2", 64'(cnt_a[2*16 +: 16]), 64'd1);

        // round-robin with all channels requesting
        set_ch(2, 23'h400, 16'd6, 32'h3333_0000);
        do_reset();
        ifa.s_wareq = 4'b1111;
        for (int i = 0; i < 8; i++) burst(i % 4, -1, 1'b0);
        ifa.s_wareq = '0;
        for (int i = 0; i < 4; i++) chk("rr_cnt", 64'(cnt_a[i*16 +: 16]), 64'd2);

        // fixed priority vs round-robin with ch0 and ch3 requesting
        do_reset();
        ifa.s_wareq = 4'b1001;
        for (int i = 0; i < 5; i++) burst(i % 2 == 1 ? 3 : 0, 0, 1'b0);
        ifa.s_wareq = '0;
        chk("fp_cnt0", 64'(cnt_b[0 +: 16]), 64'd5);
        chk("fp_cnt3", 64'(cnt_b[3*16 +: 16]), 64'd0);
        chk("rr2_cnt0", 64'(cnt_a[0 +: 16]), 64'd3);
        chk("rr2_cnt3", 64'(cnt_a[3*16 +: 16]), 64'd2);

        // withdrawal before acceptance
        @(negedge ui_clk);
        ifa.s_wareq = 4'b0010;
        @(negedge ui_clk);
        chk("wd_wareq", 64'(ifa.fdma_wareq), 64'd1);
        chk("wd_grant", 64'(grant_a), 64'h2);
        ifa.s_wareq = '0;
        @(negedge ui_clk);
        chk("wd_wareq_off", 64'(ifa.fdma_wareq), 64'd0);
        chk("wd_grant_off", 64'(grant_a), 64'd0);
        chk("wd_cnt1", 64'(cnt_a[16 +: 16]), 64'd0);
        ifa.s_wareq = 4'b0010;
        burst(1, 1, 1'b1);
        chk("wd_cnt1_after", 64'(cnt_a[16 +: 16]), 64'd1);

        // data isolation and stray wvalid while idle
        set_ch(0, 23'h100, 16'd8, 32'hAAAA_5555);
        for (int i = 1; i < 4; i++) set_ch(i, addr[i], size[i], 32'hFFFF_FFFF);
        ifa.fdma_wvalid = 1'b1;
        #1;
        chk("idle_wvalid", 64'(ifa.s_wvalid), 64'd0);
        chk("idle_wdata", 64'(ifa.fdma_wdata), 64'd0);
        ifa.fdma_wvalid = 1'b0;
        @(negedge ui_clk);
        ifa.s_wareq = 4'b0001;
        burst(0, 0, 1'b1);

        // reset in the middle of a ch3 burst
        set_ch(3, 23'h800, 16'd50, 32'h3C3C_3C3C);
        ifa.s_wareq = 4'b1000;
        @(negedge ui_clk);
        chk("mr_grant", 64'(grant_a), 64'h8);
        ifa.fdma_wbusy = 1'b1;
        ifa.s_wareq = '0;
        @(negedge ui_clk);
        ifa.fdma_wvalid = 1'b1;
        repeat (3) @(negedge ui_clk);
        ui_rstn = 1'b0;
        #1;
        chk("mr_wareq", 64'(ifa.fdma_wareq), 64'd0);
        chk("mr_grant0", 64'(grant_a), 64'd0);
        chk("mr_s_wbusy", 64'(ifa.s_wbusy), 64'd0);
        chk("mr_cnt", cnt_a, 64'd0);
        chk("mr_cnt_fp", cnt_b, 64'd0);
        chk("mr_s_wvalid", 64'(ifa.s_wvalid), 64'd0);
        ifa.fdma_wbusy = 1'b0;
        ifa.fdma_wvalid = 1'b0;
        ifa.s_wareq = 4'b1010;
        @(negedge ui_clk);
        ui_rstn = 1'b1;
        @(negedge ui_clk);
        chk("mr_first_rr", 64'(grant_a), 64'h2);
        ifa.s_wareq = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fdma_wr_arbiter_n.md
Name: fdma_wr_arbiter_n

Overview:
- Parametrised N-channel successor to the 4-way FDMA write interconnect.
- Arbitrates burst requests from CH_NUM uidbuf write ports onto one FDMA write master.
- Selectable arbitration mode: fixed priority or round-robin.
- Supports request withdrawal before acceptance, and per-channel burst counters for bandwidth debug.

Parameters:
- CH_NUM, 4, number of write channels (2..8).
- AXI_DATA_WIDTH, 32, FDMA data width.
- AXI_ADDR_WIDTH, 23, FDMA address width.
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- CNT_WIDTH, 16, width of each per-channel burst counter.

Ports:
- ui_clk  in  1  system clock for all logic.
- ui_rstn  in  1  asynchronous active-low reset.
- s_waddr  in  CH_NUM*AXI_ADDR_WIDTH  channel burst addresses; channel i in slice [i*AW +: AW].
- s_wareq  in  CH_NUM  channel burst requests.
- s_wsize  in  CH_NUM*16  channel burst lengths in beats.
- s_wbusy  out  CH_NUM  per-channel busy back to uidbuf.
- s_wdata  in  CH_NUM*AXI_DATA_WIDTH  channel write data.
- s_wvalid  out  CH_NUM  per-channel data strobe.
- fdma_waddr  out  AXI_ADDR_WIDTH  to FDMA.
- fdma_wareq  out  1  to FDMA.
- fdma_wsize  out  16  to FDMA.
- fdma_wbusy  in  1  from FDMA.
- fdma_wdata  out  AXI_DATA_WIDTH  to FDMA.
- fdma_wvalid  in  1  from FDMA.
- grant_o  out  CH_NUM  one-hot current owner; 0 when idle.
- burst_cnt_o  out  CH_NUM*CNT_WIDTH  completed bursts per channel; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, ui_rstn=0):
  - state=IDLE; grant_o=0; fdma_wareq=0; s_wbusy=0.
  - rr_ptr=CH_NUM-1, so channel 0 is searched first.
  - burst counters=0.
  - Combinational outputs evaluate to 0 under grant_o=0.
- FSM states: IDLE, REQ, BUSY.
- IDLE:
  - If any s_wareq bit is set, pick the winner.
  - Mode 0: lowest set index wins.
  - Mode 1: first set index searching rr_ptr+1, rr_ptr+2, … modulo CH_NUM.
  - Next edge: grant_o=onehot(winner), latch fdma_waddr/fdma_wsize from the winner's slice, fdma_wareq=1, state→REQ.
  - Latency: s_wareq seen at edge k → fdma_wareq high after edge k+1.
- REQ:
  - fdma_wareq held at 1; address and size stay stable.
  - If fdma_wbusy=1: fdma_wareq→0, state→BUSY.
  - Else if the owner's s_wareq=0 (withdrawal): fdma_wareq→0, grant_o→0, state→IDLE; no counter increment, rr_ptr unchanged.
  - If fdma_wbusy=1 and withdrawal occur in the same cycle, fdma_wbusy wins and the burst proceeds.
- BUSY:
  - Stay while fdma_wbusy=1.
  - On fdma_wbusy=0: owner's burst_cnt+1, rr_ptr=owner, grant_o→0, state→IDLE.
- At least one IDLE cycle separates consecutive bursts; new requests are not sampled in BUSY.
- s_wbusy[i] = grant_o[i] while state is REQ or BUSY, registered with grant.
- Data path, combinational with zero latency:
  - fdma_wdata = owner's s_wdata slice; 0 when grant_o=0.
  - s_wvalid[i] = fdma_wvalid & grant_o[i].
  - fdma_wvalid while not in BUSY/REQ is dropped; no channel sees it.
- Requests from non-owners are held off and never lost; uidbuf keeps s_wareq high until served.
- CH_NUM not a power of two: the round-robin index wraps at CH_NUM, never at 2^n.
- Mid-burst reset: all outputs return to reset values immediately; the FDMA is responsible for its own abort.

Test Plan:
- Single request: ch2 s_wareq=1, s_waddr=0x400, s_wsize=256; FDMA raises wbusy 3 cycles after wareq, issues 256 wvalid, drops wbusy → fdma_wareq high 1 cycle after request, fdma_waddr=0x400, exactly 256 s_wvalid[2] pulses, burst_cnt[2]=1, grant_o=0 afterwards.
- Round-robin, all 4 channels requesting continuously for 8 bursts → grant order 0,1,2,3,0,1,2,3; each burst_cnt=2.
- ARB_MODE=0, ch0 and ch3 requesting continuously for 5 bursts → all 5 granted to ch0; ch3 count stays 0.
- Withdrawal: ch1 granted, s_wareq[1] drops before wbusy → fdma_wareq drops next edge; no counter change; the next request from ch1 is granted normally.
- Data isolation: ch0 owner with s_wdata0=0xAAAA5555, other channels 0xFFFFFFFF → fdma_wdata=0xAAAA5555 on every wvalid beat; s_wvalid[1..3] never asserted.
- Reset asserted mid-BUSY of ch3 → fdma_wareq, grant_o, s_wbusy and counters are 0 in the same cycle; after release, the first round-robin grant goes to the lowest requester.
